matchstick_turn_sequencer: RTL
==============================

Name: matchstick_turn_sequencer

Overview:
- Sequences a two-player matchstick game. Owns the shared stick pile and arbitrates whose turn it is.
- Debounces the start button and both per-player confirm buttons.
- Validates each move and enforces a per-turn timeout.
- Outputs feed the existing seven-segment driver: pile count, turn, wrong, finish.

Parameters:
- INIT_STICKS, 100, pile size loaded at game start (1..65535).
- MAX_TAKE, 10, largest legal move (1..15).
- DEB_CYCLES, 64, consecutive high samples needed for a debounced press.
- TIMEOUT_CYCLES, 500000000, cycles allowed per turn before a forced move.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start_btn  in  1  raw start/restart pushbutton.
- p0_btn  in  1  raw confirm pushbutton, player 0.
- p1_btn  in  1  raw confirm pushbutton, player 1.
- p0_take  in  4  player 0 move switches.
- p1_take  in  4  player 1 move switches.
- sticks  out  16  current pile count.
- turn  out  1  player to move (0/1).
- wrong  out  1  last attempted move was illegal; held until the next legal move or restart.
- finish  out  1  game over.
- winner  out  1  winning player; valid while finish=1.
- timeout_pulse  out  1  one-cycle pulse when a forced move is applied.
- active  out  1  game in progress.

Behaviour:
- Reset (rst=1 at posedge clk):
  - sticks=INIT_STICKS; turn=0; wrong=0; finish=0; winner=0; timeout_pulse=0; active=0.
  - State IDLE; turn timer cleared; debouncer shift state cleared.
  - Reset mid-game abandons the game with no other side effect.
- Debounce, per button:
  - Debounced level goes to 1 after DEB_CYCLES consecutive samples of 1, and back to 0 on the first sample of 0.
  - press = one-cycle pulse on the 0->1 edge of the debounced level. A held button produces exactly one press.
- States:
  - IDLE: start press -> load INIT_STICKS, turn=0, clear wrong/finish, timer=0, active=1 -> WAIT_MOVE.
  - WAIT_MOVE:
    - Only the current player's press is considered; the other player's press is ignored.
    - take = current player's switches (4-bit, zero-extended to 16).
    - Illegal if take==0, take>MAX_TAKE, or take>sticks. Illegal press -> wrong=1, pile/turn unchanged, timer keeps running.
    - Legal press: sticks <= sticks-take on the same clock edge, so the new value is visible the cycle after the press pulse. Also wrong=0, timer=0.
    - If the result is 0 -> GAME_OVER. Otherwise turn toggles and stay in WAIT_MOVE.
  - Timeout (WAIT_MOVE, no qualifying press, timer==TIMEOUT_CYCLES-1):
    - Forced move of 1 stick, same update path as a legal move.
    - timeout_pulse=1 for that cycle; wrong cleared.
  - GAME_OVER:
    - The player who removed the last stick loses: winner = !turn_at_last_move, finish=1, active=0.
    - Player buttons are ignored.
    - start press -> restart exactly as from IDLE. finish stays 1 until that restart.
- Simultaneous events:
  - A legal or illegal press in the timeout cycle takes priority; no forced move that cycle.
  - Both player buttons pressing in the same cycle: only turn's button counts.
  - start press during WAIT_MOVE is ignored.
- Widths and arithmetic:
  - Subtraction only after the take<=sticks check, so no underflow.
  - Timer width is clog2(TIMEOUT_CYCLES); it saturates and never wraps.

Decomposition:
- Package matchstick_pkg:
  - state enum: IDLE, WAIT_MOVE, GAME_OVER.
  - player id type (1 bit).
  - STICK_W=16, TAKE_W=4.
- Sub-module btn_debounce (parameter DEB_CYCLES; ports clk, rst, raw, level, press), instantiated three times.
- Move validation is combinational inside the top module.

Test Plan (INIT_STICKS=12, MAX_TAKE=3, DEB_CYCLES=4, TIMEOUT_CYCLES=20):
- Reset then start held 4 cycles -> active=1, sticks=12, turn=0, wrong=0, finish=0.
- p0_take=3, p0_btn held 4 cycles -> one cycle after the press pulse sticks=9, turn=1. Button held 50 more cycles -> no second move.
- turn=1, p1_take=0, then 4, then 10 (pile 9) with presses -> wrong=1 each time, sticks=9, turn=1. Then p1_take=2 -> sticks=7, wrong=0, turn=0.
- p1_btn pressed while turn=0 -> no change. Idle for 20 cycles -> timeout_pulse for one cycle, sticks=6, turn=1.
- Play down to sticks=2 on turn 0: p0 takes 1, then p1 takes 1 -> sticks=0, finish=1, winner=0, active=0. Further p0/p1 presses -> no change. start -> sticks=12, finish=0.
- Assert rst mid-game (sticks=5) -> all outputs at reset values and state IDLE on the next cycle.
- Press lands in the timeout cycle -> only the pressed move is applied, timeout_pulse=0.

Source files
------------

// File: rtl/matchstick_pkg.sv
// Shared types and widths for the matchstick turn sequencer.
package matchstick_pkg;

    localparam int STICK_W = 16;
    localparam int TAKE_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MOVE,
        GAME_OVER
    } state_e;

    typedef logic player_t;

endpackage

// File: rtl/btn_debounce.sv
// Debounces one raw pushbutton into a clean level plus a single-cycle press pulse.
// Level and press rise together, DEB_CYCLES clocks after the first high sample; no backpressure.
module btn_debounce #(
    parameter int DEB_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (!raw) begin
            cnt_d   = '0;
            level_d = 1'b0;
        end else if (!level_q) begin
            // the sample that completes the run flips the level directly
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                level_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = level_d & ~level_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/matchstick_turn_sequencer.sv
// Two-player matchstick game sequencer: owns the pile, validates moves, forces a move on turn timeout.
// Moves land one clock after the debounced press pulse; all outputs are registered, no backpressure.
module matchstick_turn_sequencer
    import matchstick_pkg::*;
#(
    parameter int INIT_STICKS    = 100,
    parameter int MAX_TAKE       = 10,
    parameter int DEB_CYCLES     = 64,
    parameter int TIMEOUT_CYCLES = 500000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_btn,
    input  logic               p0_btn,
    input  logic               p1_btn,
    input  logic [TAKE_W-1:0]  p0_take,
    input  logic [TAKE_W-1:0]  p1_take,
    output logic [STICK_W-1:0] sticks,
    output player_t            turn,
    output logic               wrong,
    output logic               finish,
    output player_t            winner,
    output logic               timeout_pulse,
    output logic               active
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic start_press, p0_press, p1_press;
    logic [2:0] unused_levels;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .clk(clk), .rst(rst), .raw(start_btn), .level(unused_levels[0]), .press(start_press)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_p0 (
        .clk(clk), .rst(rst), .raw(p0_btn), .level(unused_levels[1]), .press(p0_press)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_p1 (
        .clk(clk), .rst(rst), .raw(p1_btn), .level(unused_levels[2]), .press(p1_press)
    );

    state_e             state_q, state_d;
    logic [STICK_W-1:0] sticks_q, sticks_d;
    player_t            turn_q, turn_d;
    logic               wrong_q, wrong_d;
    logic               finish_q, finish_d;
    player_t            winner_q, winner_d;
    logic               timeout_pulse_q, timeout_pulse_d;
    logic               active_q, active_d;
    logic [TMR_W-1:0]   timer_q, timer_d;

    logic               cur_press;
    logic [STICK_W-1:0] take_ext;
    logic               take_ok;
    logic               timer_exp;
    logic               apply_move;
    logic [STICK_W-1:0] amount;

    // only the player on turn is ever listened to
    always_comb begin
        cur_press = turn_q ? p1_press : p0_press;
        take_ext  = STICK_W'(turn_q ? p1_take : p0_take);
        take_ok   = (take_ext != '0) && (take_ext <= STICK_W'(MAX_TAKE)) && (take_ext <= sticks_q);
        timer_exp = (timer_q == TMR_LAST);
    end

    always_comb begin
        state_d         = state_q;
        sticks_d        = sticks_q;
        turn_d          = turn_q;
        wrong_d         = wrong_q;
        finish_d        = finish_q;
        winner_d        = winner_q;
        timeout_pulse_d = 1'b0;
        active_d        = active_q;
        timer_d         = timer_q;
        apply_move      = 1'b0;
        amount          = '0;

        case (state_q)
            IDLE, GAME_OVER: begin
                if (start_press) begin
                    state_d  = WAIT_MOVE;
                    sticks_d = STICK_W'(INIT_STICKS);
                    turn_d   = 1'b0;
                    wrong_d  = 1'b0;
                    finish_d = 1'b0;
                    active_d = 1'b1;
                    timer_d  = '0;
                end
            end
            WAIT_MOVE: begin
                // saturating: an illegal press in the last cycle defers the forced move by one clock
                if (!timer_exp) begin
                    timer_d = timer_q + 1'b1;
                end
                if (cur_press) begin
                    if (take_ok) begin
                        apply_move = 1'b1;
                        amount     = take_ext;
                    end else begin
                        wrong_d = 1'b1;
                    end
                end else if (timer_exp) begin
                    apply_move      = 1'b1;
                    amount          = STICK_W'(1);
                    timeout_pulse_d = 1'b1;
                end
                if (apply_move) begin
                    sticks_d = sticks_q - amount;
                    wrong_d  = 1'b0;
                    timer_d  = '0;
                    if (sticks_d == '0) begin
                        state_d  = GAME_OVER;
                        finish_d = 1'b1;
                        active_d = 1'b0;
                        winner_d = ~turn_q;
                    end else begin
                        turn_d = ~turn_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            sticks_q        <= STICK_W'(INIT_STICKS);
            turn_q          <= 1'b0;
            wrong_q         <= 1'b0;
            finish_q        <= 1'b0;
            winner_q        <= 1'b0;
            timeout_pulse_q <= 1'b0;
            active_q        <= 1'b0;
            timer_q         <= '0;
        end else begin
            state_q         <= state_d;
            sticks_q        <= sticks_d;
            turn_q          <= turn_d;
            wrong_q         <= wrong_d;
            finish_q        <= finish_d;
            winner_q        <= winner_d;
            timeout_pulse_q <= timeout_pulse_d;
            active_q        <= active_d;
            timer_q         <= timer_d;
        end
    end

    assign sticks        = sticks_q;
    assign turn          = turn_q;
    assign wrong         = wrong_q;
    assign finish        = finish_q;
    assign winner        = winner_q;
    assign timeout_pulse = timeout_pulse_q;
    assign active        = active_q;

endmodule
